// File: rtl/renas_mem_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the I-fetch and data requesters.
// Optional arbitration-conflict counter enabled by defining MEM_ARB_STAT_EN.
module renas_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 14,
    parameter int RD_LAT = 1
) (
    input  logic                clk_l2,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_wen,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                stat_clr,
    output logic [15:0]         conflict_cnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t              state, state_nx;
    logic                last_d;
    logic                own_d;
    logic                own_wr;
    logic [MEM_AW-1:0]   own_addr;
    logic [DATA_W-1:0]   own_wdata;
    logic [BE_W-1:0]     own_be;
    logic [CNT_W-1:0]    wcnt;
    logic                grant;
    logic                grant_d;

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant    = 1'b1;
                    // On a tie the requester that did not win last time gets the slot.
                    grant_d  = d_req && (!i_req || !last_d);
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = own_wr ? RESP : WAIT;
            WAIT:    if (wcnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            own_d     <= 1'b0;
            own_wr    <= 1'b0;
            own_addr  <= '0;
            own_wdata <= '0;
            own_be    <= '0;
            wcnt      <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nx;
            i_ack <= (state_nx == RESP) && !own_d;
            d_ack <= (state_nx == RESP) && own_d;
            if (grant) begin
                last_d    <= grant_d;
                own_d     <= grant_d;
                own_wr    <= grant_d && d_write;
                own_addr  <= grant_d ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
                own_wdata <= d_wdata;
                own_be    <= (grant_d && d_write) ? d_be : '1;
            end
            if (state == ACCESS) begin
                wcnt <= CNT_W'(RD_LAT - 1);
            end else if (state == WAIT) begin
                wcnt <= wcnt - CNT_W'(1);
            end
            if (state == WAIT && wcnt == '0) begin
                if (own_d) d_rdata <= mem_rdata;
                else       i_rdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = (state == ACCESS);
    assign mem_wen   = (state == ACCESS) && own_wr;
    assign mem_be    = (state == ACCESS) ? own_be : '0;
    assign mem_addr  = own_addr;
    assign mem_wdata = own_wdata;

`ifdef MEM_ARB_STAT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] conflict_q;

    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if (stat_clr) begin
            conflict_q <= '0;
        end else if (grant && i_req && d_req) begin
            conflict_q <= sat_inc(conflict_q);
        end
    end

    assign conflict_cnt = conflict_q;

    logic unused_bits;
    assign unused_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                           d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};
`else
    assign conflict_cnt = '0;

    logic unused_bits;
    assign unused_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                           d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0], stat_clr};
`endif

endmodule

// File: tb/tb_renas_mem_arbiter.sv
// Bench for renas_mem_arbiter: SRAM model, transaction-timeline reference model,
// directed scenarios followed by randomized requester traffic.
module tb_renas_mem_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int MEM_AW = 14;
    localparam int RD_LAT = 3;
    localparam int BE_W   = DATA_W / 8;
    localparam int WORDS  = 1 << MEM_AW;

    logic              clk_l2 = 1'b0;
    logic              rst_n  = 1'b0;
    logic              i_req  = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req   = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_addr  = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [BE_W-1:0]   d_be    = '0;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_wen;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata;
    logic              stat_clr = 1'b0;
    logic [15:0]       conflict_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    renas_mem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT)
    ) dut (
        .clk_l2(clk_l2), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stat_clr(stat_clr), .conflict_cnt(conflict_cnt)
    );

    always #5 clk_l2 = ~clk_l2;
    always @(posedge clk_l2) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        if (i == 'h800) return 32'h0000_0013;
        if (i == 4)     return 32'h1122_3344;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // SRAM with RD_LAT read latency; between valid read beats it returns junk.
    logic [31:0] sm [WORDS];
    logic [31:0] dp [RD_LAT];
    logic        vp [RD_LAT];
    logic [31:0] junk;
    assign mem_rdata = vp[RD_LAT-1] ? dp[RD_LAT-1] : junk;

    initial begin
        for (int i = 0; i < WORDS; i++) sm[i] = pat(i);
        for (int i = 0; i < RD_LAT; i++) begin
            dp[i] <= '0;
            vp[i] <= 1'b0;
        end
        junk <= 32'hA5A5_A5A5;
        forever begin
            @(posedge clk_l2);
            dp[0] <= sm[mem_addr];
            vp[0] <= mem_en && !mem_wen;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                dp[i] <= dp[i-1];
                vp[i] <= vp[i-1];
            end
            junk <= $urandom;
            if (mem_en && mem_wen)
                for (int b = 0; b < BE_W; b++)
                    if (mem_be[b]) sm[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        end
    end

    // Reference model: one transaction at a time, outputs placed on a timeline
    // counted from the grant cycle (access at +1, ack at +2 or +2+RD_LAT).
    logic [31:0] gm [WORDS];
    bit          m_busy, m_own_d, m_wr, m_last_d, m_conf, en_e;
    int          m_k, m_done;
    logic [13:0] m_idx;
    logic [31:0] m_wd, m_val, m_rdi, m_rdd;
    logic [3:0]  m_be;
    logic [15:0] m_cnt;

    initial begin
        for (int i = 0; i < WORDS; i++) gm[i] = pat(i);
        forever begin
            @(negedge clk_l2);
            if (!rst_n) begin
                m_busy = 0; m_last_d = 1; m_rdi = '0; m_rdd = '0; m_cnt = '0;
                chk("rst_i_ack", 64'(i_ack), 64'(0));
                chk("rst_d_ack", 64'(d_ack), 64'(0));
                chk("rst_i_rdata", 64'(i_rdata), 64'(0));
                chk("rst_d_rdata", 64'(d_rdata), 64'(0));
                chk("rst_mem_en", 64'(mem_en), 64'(0));
                chk("rst_mem_wen", 64'(mem_wen), 64'(0));
                chk("rst_mem_be", 64'(mem_be), 64'(0));
                chk("rst_mem_addr", 64'(mem_addr), 64'(0));
                chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
                chk("rst_conflict_cnt", 64'(conflict_cnt), 64'(0));
            end else begin
                if (m_busy && m_k == m_done && !m_wr) begin
                    if (m_own_d) m_rdd = m_val;
                    else         m_rdi = m_val;
                end
                en_e = m_busy && m_k == 1;
                chk("mem_en", 64'(mem_en), 64'(en_e));
                chk("mem_wen", 64'(mem_wen), 64'(en_e && m_wr));
                chk("mem_be", 64'(mem_be), 64'(en_e ? (m_wr ? m_be : 4'hF) : 4'h0));
                if (en_e) begin
                    chk("mem_addr", 64'(mem_addr), 64'(m_idx));
                    if (m_wr) chk("mem_wdata", 64'(mem_wdata), 64'(m_wd));
                end
                chk("i_ack", 64'(i_ack), 64'(m_busy && m_k == m_done && !m_own_d));
                chk("d_ack", 64'(d_ack), 64'(m_busy && m_k == m_done && m_own_d));
                chk("i_rdata", 64'(i_rdata), 64'(m_rdi));
                chk("d_rdata", 64'(d_rdata), 64'(m_rdd));
                chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));

                m_conf = 0;
                if (m_busy) begin
                    if (m_k == 1) begin
                        if (m_wr) begin
                            for (int b = 0; b < BE_W; b++)
                                if (m_be[b]) gm[m_idx][8*b +: 8] = m_wd[8*b +: 8];
                        end else begin
                            m_val = gm[m_idx];
                        end
                    end
                    if (m_k == m_done) m_busy = 0;
                    else               m_k++;
                end else if (i_req || d_req) begin
                    m_conf   = i_req && d_req;
                    m_own_d  = d_req && (!i_req || !m_last_d);
                    m_last_d = m_own_d;
                    m_wr     = m_own_d && d_write;
                    m_idx    = m_own_d ? d_addr[15:2] : i_addr[15:2];
                    m_wd     = d_wdata;
                    m_be     = d_be;
                    m_busy   = 1;
                    m_k      = 1;
                    m_done   = m_wr ? 2 : 2 + RD_LAT;
                end
`ifdef MEM_ARB_STAT_EN
                if (stat_clr)                        m_cnt = '0;
                else if (m_conf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk_l2);
        #1;
    endtask

    task automatic wait_ack(input bit want_d, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_l2);
            if (want_d ? d_ack : i_ack) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no %s ack within 40 cycles", want_d ? "d" : "i");
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[15:2] = 14'($urandom_range(0, 15));
        return a;
    endfunction

    int      n, at, got, dual;
    logic [3:0] ord;
    logic    ia, da;

    initial begin
        step(); step();
        rst_n = 1'b1;
        step();
        chk("reset_state_mem_en", 64'(mem_en), 64'(0));
        chk("reset_state_i_rdata", 64'(i_rdata), 64'(0));

        // Single I read of word 0x800.
        i_req = 1'b1; i_addr = 32'h0000_2000; n = cyc;
        @(negedge clk_l2); @(negedge clk_l2);
        chk("t1_mem_en", 64'(mem_en), 64'(1));
        chk("t1_mem_addr", 64'(mem_addr), 64'h800);
        wait_ack(0, at);
        chk("t1_lat", 64'(at), 64'(n + 2 + RD_LAT));
        chk("t1_i_rdata", 64'(i_rdata), 64'h13);
        chk("t1_d_ack", 64'(d_ack), 64'(0));
        step(); i_req = 1'b0;

        // D partial write, then read back.
        step();
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        n = cyc;
        @(negedge clk_l2); @(negedge clk_l2);
        chk("t2_mem_wen", 64'(mem_wen), 64'(1));
        chk("t2_mem_be", 64'(mem_be), 64'h3);
        chk("t2_mem_addr", 64'(mem_addr), 64'h4);
        chk("t2_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        wait_ack(1, at);
        chk("t2_wr_lat", 64'(at), 64'(n + 2));
        chk("t2_wr_rdata_kept", 64'(d_rdata), 64'(0));
        step(); d_req = 1'b0; d_write = 1'b0;
        step(); d_req = 1'b1; n = cyc;
        wait_ack(1, at);
        chk("t2_rd_lat", 64'(at), 64'(n + 2 + RD_LAT));
        chk("t2_rd_data", 64'(d_rdata), 64'h1122_BEEF);
        step(); d_req = 1'b0;

        // Both requesting from reset: strict alternation starting with I.
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        step();
        i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h20;
        ord = '0; got = 0; dual = 0;
        for (int i = 0; i < 100 && got < 4; i++) begin
            @(negedge clk_l2);
            if (i_ack && d_ack) dual++;
            if (i_ack || d_ack) begin
                ord = {ord[2:0], d_ack};
                got++;
            end
        end
        chk("t3_ack_count", 64'(got), 64'(4));
        chk("t3_order", 64'(ord), 64'b0101);
        chk("t3_dual_ack", 64'(dual), 64'(0));
        step(); i_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_STAT_EN
        @(negedge clk_l2);
        chk("t6_conflicts", 64'(conflict_cnt), 64'(4));
        step(); stat_clr = 1'b1;
        step(); stat_clr = 1'b0;
        @(negedge clk_l2);
        chk("t6_clear", 64'(conflict_cnt), 64'(0));
`else
        @(negedge clk_l2);
        chk("t6_tied_zero", 64'(conflict_cnt), 64'(0));
`endif

        // Reset asserted while waiting on the SRAM.
        step();
        d_req = 1'b1; d_write = 1'b0; d_addr = 32'h20;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("t5_d_rdata", 64'(d_rdata), 64'(0));
        chk("t5_i_rdata", 64'(i_rdata), 64'(0));
        chk("t5_mem_addr", 64'(mem_addr), 64'(0));
        chk("t5_d_ack", 64'(d_ack), 64'(0));
        d_req = 1'b0;
        step(); step(); rst_n = 1'b1;
        step();
        i_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_l2);
            if (i_ack || d_ack) break;
        end
        chk("t5_first_i", 64'(i_ack), 64'(1));
        chk("t5_first_not_d", 64'(d_ack), 64'(0));
        step(); i_req = 1'b0;
        wait_ack(1, at);
        step(); d_req = 1'b0;

        // Randomized traffic with occasional resets and statistic clears.
        ia = 1'b0; da = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_l2);
            ia = i_ack; da = d_ack;
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            stat_clr = ($urandom_range(0, 99) == 0);
            if (i_req && !ia) begin
                if ($urandom_range(0, 29) == 0) i_req = 1'b0;
            end else begin
                i_req = 1'($urandom_range(0, 1));
                if (i_req) i_addr = rand_addr();
            end
            if (d_req && !da) begin
                if ($urandom_range(0, 29) == 0) d_req = 1'b0;
            end else begin
                d_req = 1'($urandom_range(0, 1));
                if (d_req) begin
                    d_write = 1'($urandom_range(0, 1));
                    d_addr  = rand_addr();
                    d_wdata = $urandom;
                    d_be    = 4'($urandom_range(0, 15));
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0; stat_clr = 1'b0; rst_n = 1'b1;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/renas_mem_arbiter.md
Name: renas_mem_arbiter

Overview:
Round-robin arbiter and sequencer that shares one single-port synchronous SRAM between the instruction-fetch and data requesters of the renas mcu. It sits between the two memory-side request channels and the SRAM macro. It serialises accesses, issues one SRAM cycle per grant, waits the SRAM read latency and returns a one-cycle registered acknowledge with read data to the owner.

Parameters:
DATA_W, 32, data width of requester and SRAM data buses
ADDR_W, 32, requester byte-address width
MEM_AW, 14, SRAM word-address width; mem_addr = addr[MEM_AW+1:2]
RD_LAT, 1, SRAM read latency in clk_l2 cycles (legal range 1..4)

Ports:
clk_l2  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  instruction request; held high until i_ack
i_addr  in  ADDR_W  instruction byte address
i_ack  out  1  one-cycle completion pulse to I requester
i_rdata  out  DATA_W  read data, valid while i_ack=1
d_req  in  1  data request; held until d_ack
d_write  in  1  1=write, 0=read
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  write data
d_be  in  DATA_W/8  byte enables for writes
d_ack  out  1  one-cycle completion pulse to D requester
d_rdata  out  DATA_W  read data, valid while d_ack=1 on reads
mem_en  out  1  SRAM access strobe
mem_wen  out  1  SRAM write enable
mem_addr  out  MEM_AW  SRAM word address
mem_wdata  out  DATA_W  SRAM write data
mem_be  out  DATA_W/8  SRAM byte enables
mem_rdata  in  DATA_W  SRAM read data, RD_LAT cycles after mem_en
stat_clr  in  1  clears statistics counter (MEM_ARB_STAT_EN only)
conflict_cnt  out  16  arbitration-conflict counter

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk_l2. All outputs 0; state IDLE; last_grant=D, so I wins the first tie.
- Request inputs, address, data, byte enables and d_write are latched into owner registers on the IDLE->ACCESS edge. mem_* outputs are driven only from these registers. mem_en, mem_wen and mem_be are 0 outside ACCESS.
- FSM:
  - IDLE: if exactly one req, grant it. If both, grant the requester that is not last_grant. Update last_grant, then go to ACCESS. With no req, stay in IDLE.
  - ACCESS (1 cycle): mem_en=1, mem_wen=owner write, mem_be=d_be on D writes, else all-ones. For a write, go to RESP. For a read, go to WAIT with wait counter = RD_LAT-1.
  - WAIT: decrement the counter. At counter 0, capture mem_rdata into the owner's rdata register and go to RESP.
  - RESP (1 cycle): owner ack=1, then return to IDLE. There is no back-to-back grant, so there is one idle cycle minimum between accesses.
- Latency, counted from the cycle N in which req is first seen in IDLE:
  - read ack in cycle N+2+RD_LAT;
  - write ack in cycle N+2.
- Instruction port is read-only; i_write does not exist.
- rdata registers hold their last value between acks. Writes leave d_rdata unchanged.
- If a requester drops req before ack, the latched access still completes and ack is still pulsed. A req that arrives during a busy access waits in IDLE arbitration.
- A request held continuously across its own ack is treated as a new request in the next IDLE.
- Fairness: with both req permanently high, grants alternate I,D,I,D.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. No ack is issued for the aborted access, and an in-flight write may or may not have reached the SRAM.

Optional Feature:
MEM_ARB_STAT_EN:
- Defined: conflict_cnt increments by 1 on each IDLE grant where i_req and d_req are both high. It saturates at 16'hFFFF and is cleared to 0 on stat_clr=1; clear has priority over increment. Reset value is 0.
- Not defined: conflict_cnt is tied to 0, stat_clr is ignored, and no counter flops are present.

Test Plan:
1. Single I read, RD_LAT=1, SRAM word 0x0800 = 0x00000013, i_addr=0x00002000 -> mem_en, addr 0x0800 at N+1; i_ack=1 with i_rdata=0x00000013 at N+3; d_ack stays 0.
2. D write: d_addr=0x10, wdata=0xDEADBEEF, be=4'b0011 -> mem_wen=1, mem_be=0011, mem_addr=0x4 at N+1; d_ack at N+2. A following D read of 0x10 returns the low half updated.
3. Both req high from reset, held for 4 accesses -> grant order I,D,I,D; each ack is a single cycle; never two acks in the same cycle.
4. RD_LAT=3 I read -> i_ack at N+5 with data equal to mem_rdata sampled at N+4.
5. Assert rst_n=0 while in WAIT -> all outputs 0 immediately; after release, a new d_req is granted in IDLE and last_grant=D, so a simultaneous i_req wins.
6. With MEM_ARB_STAT_EN, 3 simultaneous-request grants -> conflict_cnt=3; stat_clr pulse -> 0; preload to 0xFFFF and add 1 more conflict -> stays at 0xFFFF.
